// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  // Two-bit arithmetic gives the 3 -> 0 wrap for free.
  function automatic idx_t next_idx(input idx_t idx);
    return idx + idx_t'(1);
  endfunction

  function automatic req_vec_t onehot(input idx_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bundle: four req/data lanes in, shared grant and data out.
interface mux4_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8
);
  req_vec_t                   req;
  logic [NUM_REQ*WIDTH-1:0]   din;
  req_vec_t                   gnt;
  idx_t                       sel;
  logic [WIDTH-1:0]           dout;
  logic                       dout_valid;
  logic                       busy;

  modport master (
    output req, din,
    input  gnt, sel, dout, dout_valid, busy
  );

  modport slave (
    input  req, din,
    output gnt, sel, dout, dout_valid, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Finds the first set bit of a 4-bit mask at or after a start index, wrapping 3 -> 0.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  req_vec_t mask,
  input  idx_t     start,
  output logic     found,
  output idx_t     idx
);

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    idx_t cand;
    // NOTE: every output gets a default before any conditional write, otherwise a latch is inferred.
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = start + idx_t'(i);
      if (mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux with bounded grant hold time.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  localparam int               HC_W     = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(MAX_HOLD);

  state_e          state_q, state_d;
  req_vec_t        gnt_q, gnt_d;
  idx_t            sel_q, sel_d;
  idx_t            ptr_q, ptr_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

  req_vec_t        others;
  logic            rel_grant;
  req_vec_t        pick_mask;
  idx_t            pick_start;
  logic            pick_found;
  idx_t            pick_idx;

  logic [WIDTH-1:0] dout_c;
  logic             dout_valid_c;
  logic             busy_c;

  // Preemption only applies when someone else is actually waiting.
  assign others    = bus.req & ~onehot(sel_q);
  assign rel_grant = !bus.req[sel_q] || ((hold_cnt_q == HOLD_MAX) && (others != '0));

  // One picker serves both the idle search and the handover search.
  assign pick_mask  = (state_q == GRANT) ? others : bus.req;
  assign pick_start = (state_q == GRANT) ? next_idx(sel_q) : ptr_q;

  rr_pick4 u_pick (
    .mask  (pick_mask),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; non-blocking assignments keep all flops updating together.
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          gnt_d      = onehot(pick_idx);
          sel_d      = pick_idx;
          ptr_d      = next_idx(pick_idx);
          hold_cnt_d = HC_W'(1);
        end
      end
      GRANT: begin
        if (rel_grant && pick_found) begin
          gnt_d      = onehot(pick_idx);
          sel_d      = pick_idx;
          ptr_d      = next_idx(pick_idx);
          hold_cnt_d = HC_W'(1);
        end else if (rel_grant) begin
          state_d    = IDLE;
          gnt_d      = '0;
          ptr_d      = next_idx(sel_q);
          hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: data passes straight through from the granted lane.
  always_comb begin
    dout_c       = '0;
    dout_valid_c = |gnt_q;
    busy_c       = (state_q == GRANT);
    if (gnt_q != '0) begin
      dout_c = bus.din[int'(sel_q)*WIDTH +: WIDTH];
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.sel        = sel_q;
  assign bus.dout       = dout_c;
  assign bus.dout_valid = dout_valid_c;
  assign bus.busy       = busy_c;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_mux4_rr_arbiter;

  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  bit   cmp_en;

  mux4_rr_arbiter_if #(.WIDTH(W)) bus ();

  mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: who owns the mux, how long they have had it, where the next search starts.
  int m_owner;
  int m_last;
  int m_ptr;
  int m_run;

  function automatic int first_from(input logic [3:0] m, input int start);
    for (int o = 0; o < 4; o++) begin
      if (m[(start + o) % 4]) return (start + o) % 4;
    end
    return -1;
  endfunction

  task automatic take(input int k);
    m_owner = k;
    m_last  = k;
    m_ptr   = (k + 1) % 4;
    m_run   = 1;
  endtask

  initial begin
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_run   = 0;
  end

  always @(posedge clk) begin
    logic [3:0] r;
    logic [3:0] oth;
    r = bus.req;
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 0;
      m_ptr   = 0;
      m_run   = 0;
    end else if (m_owner < 0) begin
      if (first_from(r, m_ptr) >= 0) take(first_from(r, m_ptr));
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (!r[m_owner] || (m_run >= MAX_HOLD && oth != 4'b0)) begin
        if (oth != 4'b0) take(first_from(oth, (m_owner + 1) % 4));
        else begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
        end
      end else begin
        m_run++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0]   e_gnt;
      logic [W-1:0] e_dout;
      e_gnt  = (m_owner < 0) ? 4'b0 : (4'b1 << m_owner);
      e_dout = (m_owner < 0) ? '0 : bus.din[m_owner*W +: W];
      check("gnt",        32'(bus.gnt),        32'(e_gnt));
      check("sel",        32'(bus.sel),        32'(m_last));
      check("dout",       32'(bus.dout),       32'(e_dout));
      check("dout_valid", 32'(bus.dout_valid), 32'(m_owner >= 0));
      check("busy",       32'(bus.busy),       32'(m_owner >= 0));
    end
  end

  // Apply inputs, take one rising edge, return just after it.
  task automatic cyc(input logic [3:0] r, input logic rn);
    bus.req = r;
    rst_n   = rn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] rq;
    n_total  = 0;
    n_pass   = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b0;
    bus.req  = 4'b0;
    bus.din  = {8'hA5, 8'h12, 8'h11, 8'h10};

    // Reset with everyone requesting, then first grant goes to 0.
    cyc(4'b1111, 1'b0);
    cmp_en = 1'b1;
    cyc(4'b1111, 1'b0);
    check("rst_gnt",  32'(bus.gnt),  32'h0);
    check("rst_sel",  32'(bus.sel),  32'h0);
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    cyc(4'b1111, 1'b1);
    check("first_gnt",  32'(bus.gnt),  32'h1);
    check("first_sel",  32'(bus.sel),  32'h0);
    check("first_dout", 32'(bus.dout), 32'h10);

    // All requesting: each grant lasts exactly MAX_HOLD cycles, rotating 0,1,2,3,0.
    prev = 4'b0001;
    for (int g = 1; g <= 4; g++) begin
      for (int c = 1; c < MAX_HOLD; c++) begin
        cyc(4'b1111, 1'b1);
        check("rot_hold",  32'(bus.gnt),        32'(prev));
        check("rot_valid", 32'(bus.dout_valid), 32'h1);
      end
      cyc(4'b1111, 1'b1);
      prev = 4'b0001 << (g % 4);
      check("rot_next", 32'(bus.gnt), 32'(prev));
    end

    // Lone requester 2 keeps the grant indefinitely.
    cyc(4'b0100, 1'b1);
    for (int c = 0; c < 10; c++) begin
      check("lone_gnt",  32'(bus.gnt),  32'h4);
      check("lone_busy", 32'(bus.busy), 32'h1);
      cyc(4'b0100, 1'b1);
    end
    cyc(4'b0000, 1'b1);
    check("drop_gnt",  32'(bus.gnt),  32'h0);
    check("drop_busy", 32'(bus.busy), 32'h0);
    check("drop_sel",  32'(bus.sel),  32'h2);
    cyc(4'b0001, 1'b1);
    check("wrap_gnt", 32'(bus.gnt), 32'h1);

    // Handover without a bubble when the owner drops early.
    cyc(4'b0110, 1'b1);
    check("ho_gnt1", 32'(bus.gnt), 32'h2);
    cyc(4'b0110, 1'b1);
    cyc(4'b0100, 1'b1);
    check("ho_gnt2",   32'(bus.gnt),        32'h4);
    check("ho_valid",  32'(bus.dout_valid), 32'h1);

    // Reset mid-grant, then a fresh request from 3.
    cyc(4'b0100, 1'b0);
    check("mid_rst_gnt",  32'(bus.gnt),  32'h0);
    check("mid_rst_dout", 32'(bus.dout), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    cyc(4'b1000, 1'b1);
    check("post_rst_gnt", 32'(bus.gnt), 32'h8);
    check("post_rst_sel", 32'(bus.sel), 32'h3);

    // Data from the granted lane passes through combinationally.
    check("pass_a5", 32'(bus.dout), 32'hA5);
    bus.din[3*W +: W] = 8'h3C;
    #1;
    check("pass_3c", 32'(bus.dout), 32'h3C);
    bus.din[0 +: 3*W] = 24'hFFFFFF;
    #1;
    check("pass_iso", 32'(bus.dout), 32'h3C);
    for (int c = 0; c < 3; c++) begin
      cyc(4'b1000, 1'b1);
      check("pass_hold", 32'(bus.dout), 32'h3C);
    end

    // Randomized traffic; the per-cycle comparison does the checking.
    rq = 4'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      end
      bus.din = 32'($urandom);
      cyc(rq, ($urandom_range(99) != 0));
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
